// File: rtl/sha3_pkg.sv
// Shared types for the SHA-3 datapath: lane geometry, lane/coordinate types
// and the absorb controller state encoding.
package sha3_pkg;
    localparam int LANE_W = 64;
    localparam int DIM    = 5;
    localparam int NLANES = 25;

    typedef logic [LANE_W-1:0] lane_t;
    typedef logic [2:0]        coord_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ABSORB,
        PERM,
        PERM_WAIT,
        DONE
    } absorb_state_t;

    function automatic logic [4:0] lane_idx(input coord_t x, input coord_t y);
        return 5'(y) * 5'd5 + 5'(x);
    endfunction
endpackage

// File: rtl/keccak_absorb_lane_cnt.sv
// Lane walker over the 5x5 plane: x steps fastest, y advances when x wraps.
// The last flag compares the linear lane index against a caller-chosen limit.
module lane_cnt
    import sha3_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    input  logic [4:0] limit,
    output coord_t     x,
    output coord_t     y,
    output logic [4:0] idx,
    output logic       last
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            x <= '0;
            y <= '0;
        end else if (inc) begin
            if (x == coord_t'(DIM - 1)) begin
                x <= '0;
                y <= y + 3'd1;
            end else begin
                x <= x + 3'd1;
            end
        end
    end

    assign idx  = lane_idx(x, y);
    assign last = (idx == limit);

endmodule

// File: rtl/keccak_absorb.sv
// Absorb front end for the Keccak lane memory: clears the state, XORs message
// words into their lanes, and hands each full block to the permutation.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for a word flagged in_first; nothing consumed
// CLEAR     | zero all 25 lanes, one per cycle
// ABSORB    | accept words, lane <= lane ^ word, through RATE_LANES-1
// PERM      | one-cycle perm_start pulse
// PERM_WAIT | wait for perm_done; then next block or finish
// DONE      | one-cycle absorb_done pulse, back to IDLE
module keccak_absorb
    import sha3_pkg::*;
#(
    parameter int RATE_LANES = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LANE_W-1:0] in_data,
    input  logic              in_first,
    input  logic              in_last,
    output logic [2:0]        rx,
    output logic [2:0]        ry,
    input  logic [LANE_W-1:0] rd,
    output logic [2:0]        wx,
    output logic [2:0]        wy,
    output logic              wr,
    output logic [LANE_W-1:0] wd,
    output logic              perm_start,
    input  logic              perm_done,
    output logic              absorb_done,
    output logic              busy,
    output logic              err
);

    localparam logic [4:0] RATE_LAST  = 5'(RATE_LANES - 1);
    localparam logic [4:0] CLEAR_LAST = 5'(NLANES - 1);

    absorb_state_t state;
    coord_t        cx, cy;
    logic [4:0]    cnt_idx;
    logic          cnt_last, cnt_clr, cnt_inc;
    logic [4:0]    cnt_limit;
    logic          accept, last_blk, first_pend;

    assign in_ready  = (state == ABSORB);
    assign accept    = in_ready && in_valid;
    assign cnt_limit = (state == CLEAR) ? CLEAR_LAST : RATE_LAST;
    assign cnt_inc   = (state == CLEAR) || accept;
    assign cnt_clr   = (state == IDLE) || (cnt_inc && cnt_last);

    lane_cnt u_lane_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .limit (cnt_limit),
        .x     (cx),
        .y     (cy),
        .idx   (cnt_idx),
        .last  (cnt_last)
    );

    // Memory ports are combinational so a word is read, mixed and written in one cycle.
    assign wr = (state == CLEAR) || accept;
    assign wx = wr ? cx : '0;
    assign wy = wr ? cy : '0;
    assign wd = accept ? (rd ^ in_data) : '0;
    assign rx = in_ready ? cx : '0;
    assign ry = in_ready ? cy : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            perm_start  <= 1'b0;
            absorb_done <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
            last_blk    <= 1'b0;
            first_pend  <= 1'b0;
        end else begin
            perm_start  <= 1'b0;
            absorb_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_first) begin
                        state      <= CLEAR;
                        busy       <= 1'b1;
                        err        <= 1'b0;
                        first_pend <= 1'b1;
                    end
                end
                CLEAR: begin
                    err        <= 1'b0;
                    first_pend <= 1'b1;
                    if (cnt_last) state <= ABSORB;
                end
                ABSORB: begin
                    if (accept) begin
                        first_pend <= 1'b0;
                        if (in_first && !first_pend) err <= 1'b1;
                        if (in_last && cnt_idx != RATE_LAST) err <= 1'b1;
                        if (cnt_last) begin
                            last_blk   <= in_last;
                            state      <= PERM;
                            perm_start <= 1'b1;
                        end
                    end
                end
                PERM: begin
                    state <= PERM_WAIT;
                end
                // perm_done only counts here, so a pulse overlapping perm_start is dropped.
                PERM_WAIT: begin
                    if (perm_done) begin
                        if (last_blk) begin
                            state       <= DONE;
                            absorb_done <= 1'b1;
                        end else begin
                            state <= ABSORB;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    last_blk <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_absorb.sv
// Directed bench for keccak_absorb with a behavioural 25-lane memory and a
// hand-driven permutation handshake.
module tb_keccak_absorb;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_first, in_last;
    logic [63:0] in_data, rd, wd;
    logic [2:0]  rx, ry, wx, wy;
    logic        wr, perm_start, perm_done, absorb_done, busy, err;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0, wnz_cnt = 0, ps_cnt = 0, ad_cnt = 0;
    logic [63:0] mem [25];

    always #5 clk = ~clk;

    keccak_absorb #(.RATE_LANES(17)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_first    (in_first),
        .in_last     (in_last),
        .rx          (rx),
        .ry          (ry),
        .rd          (rd),
        .wx          (wx),
        .wy          (wy),
        .wr          (wr),
        .wd          (wd),
        .perm_start  (perm_start),
        .perm_done   (perm_done),
        .absorb_done (absorb_done),
        .busy        (busy),
        .err         (err)
    );

    always_comb begin
        rd = '0;
        if (rx < 3'd5 && ry < 3'd5) rd = mem[int'(ry) * 5 + int'(rx)];
    end

    // Memory contents are garbage after reset so CLEAR has something to erase.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 25; i++) mem[i] <= 64'hDEAD_BEEF_0000_0000 | 64'(i + 1);
        end else if (wr) begin
            if (wx < 3'd5 && wy < 3'd5) mem[int'(wy) * 5 + int'(wx)] <= wd;
            wr_cnt++;
            if (wd != 64'd0) wnz_cnt++;
        end
        if (perm_start) ps_cnt++;
        if (absorb_done) ad_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the word is taken.
    task automatic send_word(input logic [63:0] data, input logic first, input logic last);
        int k;
        in_valid = 1'b1;
        in_data  = data;
        in_first = first;
        in_last  = last;
        for (k = 0; k < 100; k++) begin
            if (in_ready) break;
            @(negedge clk);
        end
        chk("word_accept_timeout", 64'(k < 100), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic start_msg(input logic [63:0] data);
        int n, b_wr, b_nz, nz_lanes;
        b_wr     = wr_cnt;
        b_nz     = wnz_cnt;
        in_valid = 1'b1;
        in_first = 1'b1;
        in_last  = 1'b0;
        in_data  = data;
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (in_ready) break;
        end
        chk("clear_cycles", 64'(n), 64'd26);
        chk("clear_writes", 64'(wr_cnt - b_wr), 64'd25);
        chk("clear_nonzero_wd", 64'(wnz_cnt - b_nz), 64'd0);
        nz_lanes = 0;
        for (int i = 0; i < 25; i++) if (mem[i] !== 64'd0) nz_lanes++;
        chk("clear_lanes_zero", 64'(nz_lanes), 64'd0);
        chk("clear_err", 64'(err), 64'd0);
    endtask

    task automatic wait_perm();
        int k;
        for (k = 0; k < 100; k++) begin
            if (perm_start) break;
            @(negedge clk);
        end
        chk("perm_start_seen", 64'(perm_start), 64'd1);
    endtask

    task automatic pulse_done_after(input int dly);
        repeat (dly) @(negedge clk);
        perm_done = 1'b1;
        @(negedge clk);
        perm_done = 1'b0;
    endtask

    task automatic wait_absorb_done();
        int k;
        for (k = 0; k < 100; k++) begin
            if (absorb_done) break;
            @(negedge clk);
        end
        chk("absorb_done_seen", 64'(absorb_done), 64'd1);
        @(negedge clk);
        chk("done_idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        int b_wr, b_ps, b_ad, bad;
        logic any_busy, any_ready;
        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        in_data = '0; perm_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wr", 64'(wr), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_perm_start", 64'(perm_start), 64'd0);
        chk("rst_absorb_done", 64'(absorb_done), 64'd0);
        chk("rst_ports", {52'd0, rx, ry, wx, wy}, 64'd0);
        chk("rst_wd", wd, 64'd0);
        rst = 1'b0;

        // in_valid without in_first is held off in IDLE
        in_valid = 1'b1; in_data = 64'h1234;
        b_wr = wr_cnt; any_busy = 1'b0; any_ready = 1'b0;
        repeat (10) begin
            @(negedge clk);
            any_busy  |= busy;
            any_ready |= in_ready;
        end
        chk("idle_ready", 64'(any_ready), 64'd0);
        chk("idle_busy", 64'(any_busy), 64'd0);
        chk("idle_writes", 64'(wr_cnt - b_wr), 64'd0);
        chk("idle_err", 64'(err), 64'd0);

        // single block of walking ones, stray perm_done mid-block
        b_ps = ps_cnt; b_ad = ad_cnt;
        start_msg(64'h1);
        for (int i = 0; i < 17; i++) begin
            send_word(64'h1 << i, i == 0, i == 16);
            if (i == 5) begin
                perm_done = 1'b1;
                @(negedge clk);
                perm_done = 1'b0;
                chk("absorb_ignores_perm_done", 64'(in_ready), 64'd1);
            end
        end
        wait_perm();
        pulse_done_after(5);
        wait_absorb_done();
        chk("blk1_perm_starts", 64'(ps_cnt - b_ps), 64'd1);
        chk("blk1_absorb_dones", 64'(ad_cnt - b_ad), 64'd1);
        chk("blk1_lane16", mem[16], 64'h1_0000);
        bad = 0;
        for (int i = 0; i < 25; i++) if (mem[i] !== ((i < 17) ? (64'h1 << i) : 64'd0)) bad++;
        chk("blk1_lanes_bad", 64'(bad), 64'd0);
        chk("blk1_err", 64'(err), 64'd0);

        // two identical blocks cancel; perm_done coincident with perm_start is dropped
        b_ps = ps_cnt; b_ad = ad_cnt;
        start_msg(64'hA5A5_A5A5_A5A5_A5A5);
        for (int i = 0; i < 17; i++) send_word(64'hA5A5_A5A5_A5A5_A5A5, i == 0, 1'b0);
        wait_perm();
        chk("blk2a_lane0", mem[0], 64'hA5A5_A5A5_A5A5_A5A5);
        perm_done = 1'b1;
        @(negedge clk);
        perm_done = 1'b0;
        repeat (4) @(negedge clk);
        chk("coincident_done_busy", 64'(busy), 64'd1);
        chk("coincident_done_ready", 64'(in_ready), 64'd0);
        pulse_done_after(0);
        chk("blk2_back_to_absorb", 64'(in_ready), 64'd1);
        chk("blk2_no_early_done", 64'(ad_cnt - b_ad), 64'd0);
        for (int i = 0; i < 17; i++) send_word(64'hA5A5_A5A5_A5A5_A5A5, 1'b0, i == 16);
        wait_perm();
        pulse_done_after(5);
        wait_absorb_done();
        chk("blk2_perm_starts", 64'(ps_cnt - b_ps), 64'd2);
        chk("blk2_absorb_dones", 64'(ad_cnt - b_ad), 64'd1);
        bad = 0;
        for (int i = 0; i < 25; i++) if (mem[i] !== 64'd0) bad++;
        chk("blk2_lanes_nonzero", 64'(bad), 64'd0);

        // in_last on lane 3 flags err, absorption continues
        start_msg(64'h100);
        for (int i = 0; i < 17; i++) begin
            send_word(64'h100 + 64'(i), i == 0, (i == 3) || (i == 16));
            if (i == 3) chk("err_mid_last", 64'(err), 64'd1);
        end
        wait_perm();
        pulse_done_after(5);
        wait_absorb_done();
        chk("err_sticky", 64'(err), 64'd1);
        chk("err_lane3_absorbed", mem[3], 64'h103);

        // new message clears err; in_first mid-block flags it; rst abandons the block
        b_ps = ps_cnt;
        start_msg(64'h7);
        for (int i = 0; i < 8; i++) begin
            send_word(64'h7, (i == 0) || (i == 4), 1'b0);
            if (i == 4) chk("err_mid_first", 64'(err), 64'd1);
        end
        chk("pre_rst_lane4", mem[4], 64'h7);
        in_valid = 1'b1; in_data = 64'h8; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_ready", 64'(in_ready), 64'd0);
        chk("rst_mid_wr", 64'(wr), 64'd0);
        chk("rst_mid_err", 64'(err), 64'd0);
        pulse_done_after(1);
        repeat (3) @(negedge clk);
        chk("idle_ignores_perm_done", 64'(busy), 64'd0);
        chk("rst_no_perm_start", 64'(ps_cnt - b_ps), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keccak_absorb.md
Name: keccak_absorb

Overview:
- Upstream loader for the permutation block's 5x5x64 lane memory.
- Accepts a stream of pre-padded 64-bit message words, clears the state at message start, and XOR-absorbs each word into its lane through the memory's read and write ports.
- After every RATE_LANES words it hands control to the permutation block and waits for completion.
- Signals when the final block has been permuted.

Parameters:
- RATE_LANES, 17, lanes absorbed per block (1..25); 17 is the SHA3-256 rate of 1088 bits.
- LANE_W, 64, lane width in bits; fixed by the memory.

Ports:
- clk  in  1  clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  block accepts a word this cycle
- in_data  in  64  message word
- in_first  in  1  first word of a new message; qualified by in_valid
- in_last  in  1  word belongs to the final block; sampled on the last lane of a block
- rx  out  3  memory read column
- ry  out  3  memory read row
- rd  in  64  memory read data; combinational from rx/ry
- wx  out  3  memory write column
- wy  out  3  memory write row
- wr  out  1  memory write enable
- wd  out  64  memory write data
- perm_start  out  1  one-cycle pulse to the permutation block
- perm_done  in  1  permutation complete pulse
- absorb_done  out  1  one-cycle pulse; message fully absorbed and permuted
- busy  out  1  high in every state except IDLE
- err  out  1  sticky protocol error; cleared by rst or by entry to CLEAR

Behaviour:
- Lane index i maps to x = i mod 5, y = i / 5; x increments fastest.
- Lane counter: cx, cy, 3 bits each.
- Reset values: state IDLE, cx=cy=0, all outputs 0 (in_ready, wr, perm_start, absorb_done, busy, err, rx/ry/wx/wy, wd), last_blk=0.
- States: IDLE, CLEAR, ABSORB, PERM, PERM_WAIT, DONE.
- IDLE:
  - in_ready=0.
  - If in_valid && in_first, go to CLEAR. The word is not consumed.
  - in_valid without in_first is held off; no error is raised.
- CLEAR:
  - 25 cycles with wr=1, wx=cx, wy=cy, wd=0; the counter steps lane 0..24.
  - After lane 24: cx=cy=0, go to ABSORB.
  - in_ready=0 and err cleared throughout.
- ABSORB:
  - in_ready=1; rx=cx, ry=cy.
  - On in_valid && in_ready:
    - wr=1, wx=cx, wy=cy, wd = rd ^ in_data, all combinational in the same cycle; the memory commits on that edge.
    - Counter advances.
  - Zero-cycle bubble between accepted words.
  - in_last sampled on lane RATE_LANES-1 into last_blk.
  - in_last=1 on any other lane sets err; the word is still absorbed normally.
  - in_first=1 on an accepted word that is not the message's first word sets err; the word is absorbed normally.
  - After lane RATE_LANES-1 is accepted: go to PERM, cx=cy=0.
- PERM:
  - perm_start=1 for exactly one cycle; in_ready=0, wr=0.
  - Go to PERM_WAIT.
- PERM_WAIT:
  - in_ready=0; rx/ry/wr not driven active (wr=0).
  - perm_done is sampled only in this state, so a perm_done coincident with perm_start is ignored.
  - On perm_done: if last_blk, go to DONE; else go to ABSORB.
- DONE:
  - absorb_done=1 for one cycle, then return to IDLE.
  - last_blk cleared.
- busy = (state != IDLE), registered.
- Synchronous rst in any state:
  - Next edge returns to IDLE with reset values.
  - A partially absorbed block is abandoned.
  - Memory contents are undefined until the next CLEAR.
- rd is consumed only in ABSORB.
- No read-after-write hazard: consecutive words always target distinct lanes within a block. Lanes are rewritten only after a permutation.

Decomposition:
- Shared package sha3_pkg:
  - LANE_W=64, DIM=5, NLANES=25.
  - typedef lane_t (logic [63:0]), coord_t (logic [2:0]).
  - enum absorb_state_t {IDLE, CLEAR, ABSORB, PERM, PERM_WAIT, DONE}.
- One sub-module, lane_cnt:
  - x/y counter with clear and inc inputs.
  - x wraps 4->0 with y increment; exposes lane index and a last flag.
  - Last-flag limit is programmable: 24 for CLEAR, RATE_LANES-1 for ABSORB.

Test Plan:
- Reset, then IDLE with in_valid=1, in_first=0 for 10 cycles -> in_ready=0, wr=0, busy=0.
- in_first word arrives -> exactly 25 writes of wd=0 covering (x,y) (0,0)..(4,4), then in_ready=1 on cycle 26.
- One block, RATE_LANES=17, word i = 64'h1 << i, in_last on word 16 -> lanes 0..16 hold the words, lanes 17..24 hold 0. perm_start pulses once. perm_done 5 cycles later -> absorb_done pulse, return to IDLE.
- Two blocks with identical data 64'hA5A5..., model perm as a no-op -> lanes 0..16 = 0 after the second XOR; absorb_done only after the second perm_done.
- in_last on word 3, or in_first mid-block -> err=1 and stays 1. Absorption continues; err is cleared on the next CLEAR.
- rst asserted at word 8 of a block -> next cycle IDLE, busy=0, in_ready=0, perm_start never asserted. perm_done arriving in ABSORB or IDLE is ignored.
